div_seq_param: RTL and testbench
================================

# div_seq_param

Parametrised sequential integer divider, the next generation of the team's 8-bit `Division_seq`. It performs restoring division, one quotient bit per clock. It adds a generic operand width, run-time signed/unsigned mode, a start/busy/done handshake, a synchronous reset, and divide-by-zero and signed-overflow flags. It sits as a shared arithmetic resource behind a controller that issues one division at a time and waits for `done`.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 2..32.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request a division; sampled only while idle.
- `signed_mode`  in  1: 1 means two's-complement operands; 0 means unsigned. Captured with `start`.
- `dividend`  in  WIDTH: numerator, captured with `start`.
- `divisor`  in  WIDTH: denominator, captured with `start`.
- `busy`  out  1: high while a division is in progress.
- `done`  out  1: one-cycle pulse; results are valid from this cycle.
- `quotient`  out  WIDTH: result, held until the next completion.
- `remainder`  out  WIDTH: result, held until the next completion.
- `div_by_zero`  out  1: the completed operation had `divisor`==0; held with the results.
- `overflow`  out  1: the completed operation was signed most-negative / −1; held with the results.

## Operation
- States are IDLE, RUN and FIX.
- **Accept:** the edge on which state==IDLE and `start`==1.
  - Operands and `signed_mode` are latched. In signed mode their magnitudes are latched, together with the quotient sign (sign_a XOR sign_b) and the remainder sign (sign_a).
  - The internal partial remainder is cleared and the bit counter is set to WIDTH. State goes to RUN.
- **RUN**, once per edge:
  - Shift {partial remainder, dividend magnitude} left by 1.
  - If partial remainder ≥ divisor magnitude, subtract and set the new quotient LSB to 1; otherwise set it to 0.
  - Decrement the counter. After WIDTH iterations, go to FIX.
  - The partial remainder is WIDTH+1 bits wide so that the magnitude 2^(WIDTH−1) never overflows.
- **FIX**, one edge:
  - Apply the signs: negate the quotient if its sign is 1, and negate the remainder if its sign is 1.
  - Write `quotient`, `remainder`, `div_by_zero`=0 and `overflow`, set `done`, and go to IDLE.
- **Signed semantics:** the quotient truncates toward zero; the remainder takes the sign of the dividend.
- **Signed overflow** (−2^(WIDTH−1) / −1): `quotient` = −2^(WIDTH−1) (wraps), `remainder`=0, `overflow`=1.
- **Divide by zero**, detected at accept:
  - No RUN phase and no `busy`. State stays IDLE.
  - On the accepting edge: `quotient` = all ones, `remainder` = `dividend` (raw input), `div_by_zero`=1, `overflow`=0, `done`=1.
- **`start` while busy:** ignored, with no effect on the operation in flight.
- **Result outputs** change only on a completion edge or on reset.

## Timing
- **Reset:** every output is 0 (`busy`, `done`, `quotient`, `remainder`, `div_by_zero`, `overflow`) and state is IDLE.
- **Reset mid-operation:** `rst` overrides on the same edge; the operation is discarded and no `done` is produced.
- **Normal latency**, with accept at edge E0:
  - `busy` is high after E0 and low after E(WIDTH+1).
  - `done` is high for exactly the cycle between E(WIDTH+1) and E(WIDTH+2).
  - For WIDTH=8, `done` is observed at edge 10 after accept.
- **Back-to-back:** a new `start` may be accepted on E(WIDTH+2), i.e. in the cycle `done` is high. There is no additional idle cycle.
- **Divide-by-zero latency:** `done` is high in the cycle after E0.
- **Register placement:** all outputs are registered; no combinational path from inputs to outputs.

## Structure
- **Package `div_pkg`:**
  - State enum (IDLE, RUN, FIX).
  - A function for the two's-complement magnitude of a WIDTH-bit value.
  - Localparam for the counter width, $clog2(WIDTH+1).
- **Sub-module `div_step`:** one combinational restoring iteration (shift, compare, subtract), parametrised by WIDTH and instantiated once. Everything else lives in `div_seq_param`.

## Test plan
- **Unsigned:** WIDTH=8, `signed_mode`=0, 0x85 / 0x11 → `quotient`=0x07, `remainder`=0x0E, flags 0, `done` exactly 10 edges after accept, `busy` high for 9 cycles.
- **Signed:** `signed_mode`=1, 0x85 (−123) / 0x11 (17) → `quotient`=0xF9 (−7), `remainder`=0xFC (−4). Also 0x85 / 0xEF (−17) → `quotient`=0x07, `remainder`=0xFC.
- **Divide by zero:** 0x85 / 0x00, both modes → `quotient`=0xFF, `remainder`=0x85, `div_by_zero`=1, `done` 1 cycle after accept, `busy` never high.
- **Signed overflow:** 0x80 / 0xFF → `quotient`=0x80, `remainder`=0x00, `overflow`=1.
- **Handshake:**
  - A `start` pulse with different operands mid-RUN is ignored and the results match the first operation.
  - A `start` held high through `done` → the second operation is accepted on the `done` cycle.
- **Reset and width:**
  - `rst` asserted at iteration 4 → all outputs 0 next cycle and no `done` pulse.
  - Repeat the random checks at WIDTH=16 against a reference model, 1000 vectors per mode.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential divider.
// State enum, magnitude helper, counter-width helper.
package div_pkg;

  localparam int MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  // Bits needed to hold the values 0..w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  // Two's-complement magnitude of a value sign-extended to 32 bits.
  // The low w bits hold the magnitude of the original w-bit value.
  function automatic logic [31:0] mag(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift, compare, subtract.
// rem/dq in -> rem_n/dq_n out; dvs is the divisor magnitude.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] dq,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   rem_n,
  output logic [WIDTH-1:0] dq_n
);

  localparam int RW = WIDTH + 1;
  localparam int SW = WIDTH + 2;

  logic [WIDTH+1:0] sh;
  logic             ge;

  assign sh = {rem, dq[WIDTH-1]};
  assign ge = (sh >= SW'(dvs));

  always_comb begin
    rem_n = RW'(sh);
    dq_n  = {dq[WIDTH-2:0], 1'b0};
    if (ge) begin
      rem_n = RW'(sh - SW'(dvs));
      dq_n  = {dq[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_seq_param.sv
// Sequential restoring divider, one quotient bit per clock.
// start/operands in; busy, done, quotient, remainder, flags out.
module div_seq_param
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] MINV =
    {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  state_t           state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   prem;
  logic [WIDTH:0]   prem_n;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] dq_n;
  logic [WIDTH-1:0] dvs;
  logic             qneg;
  logic             rneg;
  logic             ovf;

  logic             sa;
  logic             sb;
  logic             zero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  always_comb begin
    sa    = signed_mode & dividend[WIDTH-1];
    sb    = signed_mode & divisor[WIDTH-1];
    zero  = (divisor == '0);
    a_mag = dividend;
    b_mag = divisor;
    if (sa) a_mag = WIDTH'(mag(32'($signed(dividend))));
    if (sb) b_mag = WIDTH'(mag(32'($signed(divisor))));
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start && !zero) state_n = RUN;
      RUN:  if (cnt == CW'(1)) state_n = FIX;
      FIX:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem   (prem),
    .dq    (dq),
    .dvs   (dvs),
    .rem_n (prem_n),
    .dq_n  (dq_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      prem        <= '0;
      dq          <= '0;
      dvs         <= '0;
      qneg        <= 1'b0;
      rneg        <= 1'b0;
      ovf         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && zero) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
            done        <= 1'b1;
          end else if (start) begin
            dq   <= a_mag;
            dvs  <= b_mag;
            prem <= '0;
            cnt  <= CW'(WIDTH);
            qneg <= sa ^ sb;
            rneg <= sa;
            ovf  <= signed_mode
                    && (dividend == MINV)
                    && (divisor == '1);
            busy <= 1'b1;
          end
        end
        RUN: begin
          prem <= prem_n;
          dq   <= dq_n;
          cnt  <= cnt - CW'(1);
        end
        FIX: begin
          quotient    <= qneg ? -dq : dq;
          remainder   <= rneg ? -prem[WIDTH-1:0]
                              : prem[WIDTH-1:0];
          div_by_zero <= 1'b0;
          overflow    <= ovf;
          done        <= 1'b1;
          busy        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_param.sv
// Scoreboard bench for div_seq_param at WIDTH=8 and 16.
// Directed 8-bit vectors plus model-checked 16-bit vectors.
module tb_div_seq_param;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
    logic        o;
    string       nm;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8 = 1'b1, start8 = 1'b0, sm8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, dz8, ov8;
  logic [7:0] quo8, rem8;

  logic        rst16 = 1'b1, start16 = 1'b0, sm16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, dz16, ov16;
  logic [15:0] quo16, rem16;

  int errors = 0;
  int checks = 0;
  exp_t q8[$];
  exp_t q16[$];
  exp_t e8, e16;

  div_seq_param #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst8), .start(start8),
    .signed_mode(sm8), .dividend(a8), .divisor(b8),
    .busy(busy8), .done(done8),
    .quotient(quo8), .remainder(rem8),
    .div_by_zero(dz8), .overflow(ov8)
  );

  div_seq_param #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst16), .start(start16),
    .signed_mode(sm16), .dividend(a16), .divisor(b16),
    .busy(busy16), .done(done16),
    .quotient(quo16), .remainder(rem16),
    .div_by_zero(dz16), .overflow(ov16)
  );

  task automatic chk(input bit ok, input string nm,
                     input logic [63:0] got,
                     input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, got, req);
    end
  endtask

  always @(negedge clk) begin
    if (done8) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL u8 unexpected done q=%h r=%h",
                 quo8, rem8);
      end else begin
        e8 = q8.pop_front();
        if (quo8 !== e8.q[7:0] || rem8 !== e8.r[7:0] ||
            dz8 !== e8.z || ov8 !== e8.o) begin
          errors++;
          $display("FAIL %s got q=%h r=%h z=%b o=%b want q=%h r=%h z=%b o=%b",
                   e8.nm, quo8, rem8, dz8, ov8,
                   e8.q[7:0], e8.r[7:0], e8.z, e8.o);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done16) begin
      checks++;
      if (q16.size() == 0) begin
        errors++;
        $display("FAIL u16 unexpected done q=%h r=%h",
                 quo16, rem16);
      end else begin
        e16 = q16.pop_front();
        if (quo16 !== e16.q || rem16 !== e16.r ||
            dz16 !== e16.z || ov16 !== e16.o) begin
          errors++;
          $display("FAIL %s got q=%h r=%h z=%b o=%b want q=%h r=%h z=%b o=%b",
                   e16.nm, quo16, rem16, dz16, ov16,
                   e16.q, e16.r, e16.z, e16.o);
        end
      end
    end
  end

  task automatic run8(input logic sm,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] eq, input logic [7:0] er,
                      input logic ez, input logic eo,
                      input string nm, input int glitch);
    exp_t e;
    int n, nb, lat;
    bit seen;
    e.q = {8'h00, eq};
    e.r = {8'h00, er};
    e.z = ez;
    e.o = eo;
    e.nm = nm;
    q8.push_back(e);
    @(negedge clk);
    sm8 = sm; a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    n = 0; nb = 0; seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy8) nb++;
      if (done8) begin
        seen = 1;
        break;
      end
      if (glitch >= 0 && n == glitch) begin
        start8 = 1'b1; sm8 = 1'b0; a8 = 8'h33; b8 = 8'h01;
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk);
      n++;
    end
    lat = ez ? 0 : 9;
    chk(seen && n == lat, {nm, " done_lat"}, 64'(n), 64'(lat));
    chk(nb == lat, {nm, " busy_cycles"}, 64'(nb), 64'(lat));
  endtask

  task automatic b2b8();
    exp_t e;
    int n;
    bit seen;
    e.q = 16'h0014; e.r = 16'h0000; e.z = 0; e.o = 0;
    e.nm = "b2b_op1";
    q8.push_back(e);
    e.q = 16'h00fe; e.r = 16'h0001; e.nm = "b2b_op2";
    q8.push_back(e);
    @(negedge clk);
    sm8 = 1'b0; a8 = 8'hc8; b8 = 8'h0a; start8 = 1'b1;
    @(posedge clk);
    n = 0; seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done8) begin
        seen = 1;
        break;
      end
      @(posedge clk);
      n++;
    end
    chk(seen && n == 9, "b2b_op1 lat", 64'(n), 64'd9);
    sm8 = 1'b1; a8 = 8'h09; b8 = 8'hfc;
    @(posedge clk);
    #1 start8 = 1'b0;
    n = 0; seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (n == 0)
        chk(busy8 === 1'b1, "b2b_busy_after_accept",
            64'(busy8), 64'd1);
      if (done8) begin
        seen = 1;
        break;
      end
      @(posedge clk);
      n++;
    end
    chk(seen && n == 9, "b2b_op2 lat", 64'(n), 64'd9);
  endtask

  task automatic rst_mid8();
    int nd;
    @(negedge clk);
    sm8 = 1'b0; a8 = 8'h85; b8 = 8'h11; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({busy8, done8, quo8, rem8, dz8, ov8} === '0,
        "mid_reset_outputs",
        64'({busy8, done8, quo8, rem8, dz8, ov8}), 64'd0);
    rst8 = 1'b0;
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done8 || busy8) nd++;
    end
    chk(nd == 0, "mid_reset_no_done", 64'(nd), 64'd0);
  endtask

  task automatic model16(input logic sm,
                         input logic [15:0] a,
                         input logic [15:0] b,
                         output exp_t e);
    int sa, sb, q, r;
    e.z = 0; e.o = 0; e.nm = "rand16";
    if (b == 16'h0000) begin
      q = 32'h0000ffff; r = int'(a); e.z = 1;
    end else if (sm) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sa == -32768 && sb == -1) begin
        q = -32768; r = 0; e.o = 1;
      end else begin
        q = sa / sb; r = sa % sb;
      end
    end else begin
      q = int'(a) / int'(b);
      r = int'(a) % int'(b);
    end
    e.q = 16'(q);
    e.r = 16'(r);
  endtask

  task automatic run16(input logic sm,
                       input logic [15:0] a,
                       input logic [15:0] b);
    exp_t e;
    int n, lat;
    bit seen;
    model16(sm, a, b, e);
    q16.push_back(e);
    @(negedge clk);
    sm16 = sm; a16 = a; b16 = b; start16 = 1'b1;
    @(posedge clk);
    #1 start16 = 1'b0;
    n = 0; seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done16) begin
        seen = 1;
        break;
      end
      @(posedge clk);
      n++;
    end
    lat = e.z ? 0 : 17;
    chk(seen && n == lat, "rand16 done_lat", 64'(n), 64'(lat));
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rsm;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({busy8, done8, quo8, rem8, dz8, ov8} === '0,
        "reset8", 64'({busy8, done8, quo8, rem8, dz8, ov8}), 64'd0);
    chk({busy16, done16, quo16, rem16, dz16, ov16} === '0,
        "reset16",
        64'({busy16, done16, quo16, rem16, dz16, ov16}), 64'd0);
    rst8 = 1'b0;
    rst16 = 1'b0;

    run8(0, 8'h85, 8'h11, 8'h07, 8'h0e, 0, 0, "u_85_11", -1);
    run8(1, 8'h85, 8'h11, 8'hf9, 8'hfc, 0, 0, "s_85_11", -1);
    run8(1, 8'h85, 8'hef, 8'h07, 8'hfc, 0, 0, "s_85_ef", -1);
    run8(0, 8'h85, 8'h00, 8'hff, 8'h85, 1, 0, "u_dbz", -1);
    run8(1, 8'h85, 8'h00, 8'hff, 8'h85, 1, 0, "s_dbz", -1);
    run8(1, 8'h80, 8'hff, 8'h80, 8'h00, 0, 1, "s_ovf", -1);
    run8(0, 8'h80, 8'hff, 8'h00, 8'h80, 0, 0, "u_80_ff", -1);
    run8(0, 8'hff, 8'h01, 8'hff, 8'h00, 0, 0, "u_ff_01", -1);
    run8(1, 8'h7f, 8'h80, 8'h00, 8'h7f, 0, 0, "s_7f_80", -1);
    run8(1, 8'h80, 8'h01, 8'h80, 8'h00, 0, 0, "s_80_01", -1);
    run8(1, 8'h80, 8'h02, 8'hc0, 8'h00, 0, 0, "s_80_02", -1);
    run8(0, 8'h64, 8'h07, 8'h0e, 8'h02, 0, 0, "glitch", 3);
    b2b8();
    rst_mid8();
    run8(0, 8'h85, 8'h11, 8'h07, 8'h0e, 0, 0, "after_rst", -1);

    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 1000; i++) begin
        rsm = (m == 1);
        ra = 16'($urandom);
        rb = 16'($urandom);
        if (i % 4 == 2) rb = rb & 16'h000f;
        if (i % 64 == 0) rb = 16'h0000;
        if (i % 64 == 1) begin
          ra = 16'h8000;
          rb = 16'hffff;
        end
        run16(rsm, ra, rb);
      end
    end

    @(negedge clk);
    chk(q8.size() == 0, "q8_drained", 64'(q8.size()), 64'd0);
    chk(q16.size() == 0, "q16_drained", 64'(q16.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
